// File: rtl/conv_layer_address_gen_if.sv
// Handshake bundle between the layer controller / memories and the convolution address sequencer.
// The master side is the sequencer itself; the slave side is the controller and memory consumers.
interface conv_layer_address_gen_if #(
    parameter int IN_ADDR_W = 10,
    parameter int W_ADDR_W  = 8,
    parameter int OX_W      = 5,
    parameter int OY_W      = 5
);
    logic                 start;
    logic                 abort;
    logic                 in_ready;
    logic [3:0]           st;
    logic [W_ADDR_W-1:0]  w_addr;
    logic                 w_valid;
    logic [IN_ADDR_W-1:0] in_addr;
    logic                 in_valid;
    logic                 win_first;
    logic                 win_last;
    logic [OX_W-1:0]      out_x;
    logic [OY_W-1:0]      out_y;
    logic                 done;

    modport master (
        input  start, abort, in_ready,
        output st, w_addr, w_valid, in_addr, in_valid,
               win_first, win_last, out_x, out_y, done
    );

    modport slave (
        output start, abort, in_ready,
        input  st, w_addr, w_valid, in_addr, in_valid,
               win_first, win_last, out_x, out_y, done
    );
endinterface

// File: rtl/conv_layer_address_gen.sv
// Layer sequencer: streams weight-ROM addresses, then input-RAM addresses for every tap of every
// output window (loop order kx, ky, c, ox, oy) with valid/ready backpressure, abort and done pulse.
module conv_layer_address_gen #(
    parameter int IN_W      = 32,
    parameter int IN_H      = 32,
    parameter int IN_CH     = 1,
    parameter int K         = 5,
    parameter int STRIDE    = 1,
    parameter int OUT_MAPS  = 6,
    parameter int OUT_W     = (IN_W - K) / STRIDE + 1,
    parameter int OUT_H     = (IN_H - K) / STRIDE + 1,
    parameter int W_WORDS   = OUT_MAPS * IN_CH * K * K + OUT_MAPS,
    parameter int IN_ADDR_W = $clog2(IN_CH * IN_W * IN_H),
    parameter int W_ADDR_W  = $clog2(W_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    conv_layer_address_gen_if.master    bus
);

    localparam int OX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int KX_W = (K > 1) ? $clog2(K) : 1;
    localparam int C_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_LOAD_W = 4'b0010;
    localparam logic [3:0] ST_CALC   = 4'b0100;
    localparam logic [3:0] ST_DONE   = 4'b1000;

    localparam logic [W_ADDR_W-1:0] W_LAST = W_ADDR_W'(W_WORDS - 1);

    // Address steps for each loop level; all products are elaboration-time constants.
    localparam logic [IN_ADDR_W-1:0] ROW_STEP   = IN_ADDR_W'(IN_W);
    localparam logic [IN_ADDR_W-1:0] PLANE_STEP = IN_ADDR_W'(IN_W * IN_H);
    localparam logic [IN_ADDR_W-1:0] X_STEP     = IN_ADDR_W'(STRIDE);
    localparam logic [IN_ADDR_W-1:0] Y_STEP     = IN_ADDR_W'(STRIDE * IN_W);

    localparam logic [KX_W-1:0] K_LAST  = KX_W'(K - 1);
    localparam logic [C_W-1:0]  C_LAST  = C_W'(IN_CH - 1);
    localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
    localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);
    localparam logic            SINGLE_TAP = (K == 1) && (IN_CH == 1);

    logic [3:0]           st_reg, st_next;
    logic [W_ADDR_W-1:0]  w_addr_reg, w_addr_next;
    logic                 w_valid_reg, w_valid_next;
    logic [IN_ADDR_W-1:0] in_addr_reg, in_addr_next;
    logic                 in_valid_reg, in_valid_next;
    logic                 win_first_reg, win_first_next;
    logic                 win_last_reg, win_last_next;
    logic [OX_W-1:0]      out_x_reg, out_x_next;
    logic [OY_W-1:0]      out_y_reg, out_y_next;
    logic                 done_reg, done_next;

    logic [KX_W-1:0]      kx_reg, kx_next;
    logic [KX_W-1:0]      ky_reg, ky_next;
    logic [C_W-1:0]       c_reg, c_next;
    logic [OX_W-1:0]      ox_reg, ox_next;
    logic [OY_W-1:0]      oy_reg, oy_next;

    // Base addresses of the current output row, window, channel plane and filter row.
    logic [IN_ADDR_W-1:0] y_base_reg, y_base_next;
    logic [IN_ADDR_W-1:0] win_base_reg, win_base_next;
    logic [IN_ADDR_W-1:0] ch_base_reg, ch_base_next;
    logic [IN_ADDR_W-1:0] row_base_reg, row_base_next;

    logic accept;
    logic finish;
    logic clear_all;
    logic calc_entry;

    assign accept = in_valid_reg & bus.in_ready;

    always_comb begin
        st_next        = st_reg;
        w_addr_next    = w_addr_reg;
        w_valid_next   = w_valid_reg;
        in_addr_next   = in_addr_reg;
        in_valid_next  = in_valid_reg;
        win_first_next = win_first_reg;
        win_last_next  = win_last_reg;
        out_x_next     = out_x_reg;
        out_y_next     = out_y_reg;
        done_next      = 1'b0;
        kx_next        = kx_reg;
        ky_next        = ky_reg;
        c_next         = c_reg;
        ox_next        = ox_reg;
        oy_next        = oy_reg;
        y_base_next    = y_base_reg;
        win_base_next  = win_base_reg;
        ch_base_next   = ch_base_reg;
        row_base_next  = row_base_reg;
        finish         = 1'b0;
        clear_all      = 1'b0;
        calc_entry     = 1'b0;

        if (bus.abort) begin
            st_next   = ST_IDLE;
            clear_all = 1'b1;
        end else begin
            case (st_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        st_next      = ST_LOAD_W;
                        w_addr_next  = '0;
                        w_valid_next = 1'b1;
                    end
                end
                ST_LOAD_W: begin
                    if (w_addr_reg == W_LAST) begin
                        st_next    = ST_CALC;
                        clear_all  = 1'b1;
                        calc_entry = 1'b1;
                    end else begin
                        w_addr_next = w_addr_reg + 1'b1;
                    end
                end
                ST_CALC: begin
                    if (accept) begin
                        if (kx_reg != K_LAST) begin
                            kx_next      = kx_reg + 1'b1;
                            in_addr_next = in_addr_reg + 1'b1;
                        end else begin
                            kx_next = '0;
                            if (ky_reg != K_LAST) begin
                                ky_next       = ky_reg + 1'b1;
                                row_base_next = row_base_reg + ROW_STEP;
                                in_addr_next  = row_base_reg + ROW_STEP;
                            end else begin
                                ky_next = '0;
                                if (c_reg != C_LAST) begin
                                    c_next        = c_reg + 1'b1;
                                    ch_base_next  = ch_base_reg + PLANE_STEP;
                                    row_base_next = ch_base_reg + PLANE_STEP;
                                    in_addr_next  = ch_base_reg + PLANE_STEP;
                                end else begin
                                    c_next = '0;
                                    if (ox_reg != OX_LAST) begin
                                        ox_next       = ox_reg + 1'b1;
                                        win_base_next = win_base_reg + X_STEP;
                                        ch_base_next  = win_base_reg + X_STEP;
                                        row_base_next = win_base_reg + X_STEP;
                                        in_addr_next  = win_base_reg + X_STEP;
                                    end else begin
                                        ox_next = '0;
                                        if (oy_reg != OY_LAST) begin
                                            oy_next       = oy_reg + 1'b1;
                                            y_base_next   = y_base_reg + Y_STEP;
                                            win_base_next = y_base_reg + Y_STEP;
                                            ch_base_next  = y_base_reg + Y_STEP;
                                            row_base_next = y_base_reg + Y_STEP;
                                            in_addr_next  = y_base_reg + Y_STEP;
                                        end else begin
                                            finish = 1'b1;
                                        end
                                    end
                                end
                            end
                        end

                        if (finish) begin
                            st_next   = ST_DONE;
                            done_next = 1'b1;
                            clear_all = 1'b1;
                        end else begin
                            win_first_next = (kx_next == '0) && (ky_next == '0) && (c_next == '0);
                            win_last_next  = (kx_next == K_LAST) && (ky_next == K_LAST) &&
                                             (c_next == C_LAST);
                            out_x_next     = ox_next;
                            out_y_next     = oy_next;
                        end
                    end
                end
                ST_DONE: begin
                    st_next   = ST_IDLE;
                    clear_all = 1'b1;
                end
                default: begin
                    st_next   = ST_IDLE;
                    clear_all = 1'b1;
                end
            endcase
        end

        if (clear_all) begin
            w_addr_next    = '0;
            w_valid_next   = 1'b0;
            in_addr_next   = '0;
            in_valid_next  = 1'b0;
            win_first_next = 1'b0;
            win_last_next  = 1'b0;
            out_x_next     = '0;
            out_y_next     = '0;
            kx_next        = '0;
            ky_next        = '0;
            c_next         = '0;
            ox_next        = '0;
            oy_next        = '0;
            y_base_next    = '0;
            win_base_next  = '0;
            ch_base_next   = '0;
            row_base_next  = '0;
        end

        // First tap of the layer is address 0 with every index at zero.
        if (calc_entry) begin
            in_valid_next  = 1'b1;
            win_first_next = 1'b1;
            win_last_next  = SINGLE_TAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg        <= ST_IDLE;
            w_addr_reg    <= '0;
            w_valid_reg   <= 1'b0;
            in_addr_reg   <= '0;
            in_valid_reg  <= 1'b0;
            win_first_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            done_reg      <= 1'b0;
            kx_reg        <= '0;
            ky_reg        <= '0;
            c_reg         <= '0;
            ox_reg        <= '0;
            oy_reg        <= '0;
            y_base_reg    <= '0;
            win_base_reg  <= '0;
            ch_base_reg   <= '0;
            row_base_reg  <= '0;
        end else begin
            st_reg        <= st_next;
            w_addr_reg    <= w_addr_next;
            w_valid_reg   <= w_valid_next;
            in_addr_reg   <= in_addr_next;
            in_valid_reg  <= in_valid_next;
            win_first_reg <= win_first_next;
            win_last_reg  <= win_last_next;
            out_x_reg     <= out_x_next;
            out_y_reg     <= out_y_next;
            done_reg      <= done_next;
            kx_reg        <= kx_next;
            ky_reg        <= ky_next;
            c_reg         <= c_next;
            ox_reg        <= ox_next;
            oy_reg        <= oy_next;
            y_base_reg    <= y_base_next;
            win_base_reg  <= win_base_next;
            ch_base_reg   <= ch_base_next;
            row_base_reg  <= row_base_next;
        end
    end

    assign bus.st        = st_reg;
    assign bus.w_addr    = w_addr_reg;
    assign bus.w_valid   = w_valid_reg;
    assign bus.in_addr   = in_addr_reg;
    assign bus.in_valid  = in_valid_reg;
    assign bus.win_first = win_first_reg;
    assign bus.win_last  = win_last_reg;
    assign bus.out_x     = out_x_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_conv_layer_address_gen.sv
// Bench for conv_layer_address_gen: a default 32x32/5x5 instance and a small 6x6x2/2x2/stride-2
// instance, checked against a nested-loop tap list built directly from the address formula.
module tb_conv_layer_address_gen;

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_LOAD = 4'b0010;
    localparam logic [3:0] S_CALC = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ox;
        logic [31:0] oy;
        logic        first;
        logic        last;
    } tap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    tap_t exp_q[$];
    tap_t got_q[$];

    always #5 clk = ~clk;

    conv_layer_address_gen_if #(.IN_ADDR_W(10), .W_ADDR_W(8), .OX_W(5), .OY_W(5)) ifa ();
    conv_layer_address_gen_if #(.IN_ADDR_W(7),  .W_ADDR_W(4), .OX_W(2), .OY_W(2)) ifb ();

    conv_layer_address_gen dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));

    conv_layer_address_gen #(
        .IN_W(6), .IN_H(6), .IN_CH(2), .K(2), .STRIDE(2), .OUT_MAPS(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: every tap of every window, straight from the address formula.
    task automatic build_model(input int in_w, input int in_h, input int in_ch,
                               input int k, input int stride);
        int ow, oh;
        tap_t t;
        exp_q.delete();
        ow = (in_w - k) / stride + 1;
        oh = (in_h - k) / stride + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < in_ch; c++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            t.addr  = 32'(c * in_w * in_h + (oy * stride + ky) * in_w + ox * stride + kx);
                            t.ox    = 32'(ox);
                            t.oy    = 32'(oy);
                            t.first = (c == 0) && (ky == 0) && (kx == 0);
                            t.last  = (c == in_ch - 1) && (ky == k - 1) && (kx == k - 1);
                            exp_q.push_back(t);
                        end
    endtask

    task automatic test_reset;
        ifa.start = 0; ifa.abort = 0; ifa.in_ready = 0;
        ifb.start = 0; ifb.abort = 0; ifb.in_ready = 0;
        rst_n = 0;
        tick; tick;
        rst_n = 1;
        tick;
        checks++;
        if (ifa.st !== S_IDLE || ifb.st !== S_IDLE) begin
            errors++;
            $display("FAIL reset_st: a=%b b=%b expected %b", ifa.st, ifb.st, S_IDLE);
        end
        checks++;
        if ({ifa.w_addr, ifa.w_valid, ifa.in_addr, ifa.in_valid, ifa.win_first, ifa.win_last,
             ifa.out_x, ifa.out_y, ifa.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a: w_addr=%0d in_addr=%0d in_valid=%b done=%b expected all 0",
                     ifa.w_addr, ifa.in_addr, ifa.in_valid, ifa.done);
        end
        checks++;
        if ({ifb.w_addr, ifb.w_valid, ifb.in_addr, ifb.in_valid, ifb.win_first, ifb.win_last,
             ifb.out_x, ifb.out_y, ifb.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b: w_addr=%0d in_addr=%0d in_valid=%b done=%b expected all 0",
                     ifb.w_addr, ifb.in_addr, ifb.in_valid, ifb.done);
        end
    endtask

    task automatic test_default_run;
        int n, cyc, dn;
        tap_t t;
        build_model(32, 32, 1, 5, 1);
        got_q.delete();
        ifa.start = 1; tick; ifa.start = 0;
        n = 0;
        while (ifa.st == S_LOAD && n < 400) begin
            checks++;
            if (ifa.w_addr !== 8'(n) || ifa.w_valid !== 1'b1) begin
                errors++;
                $display("FAIL a_load_w_addr: w_addr=%0d w_valid=%b expected %0d/1", ifa.w_addr, ifa.w_valid, n);
            end
            n++; tick;
        end
        checks++;
        if (n != 156) begin errors++; $display("FAIL a_load_len: %0d cycles expected 156", n); end
        checks++;
        if (ifa.st !== S_CALC || ifa.in_valid !== 1'b1 || ifa.w_valid !== 1'b0 || ifa.w_addr !== 8'd0) begin
            errors++;
            $display("FAIL a_calc_entry: st=%b in_valid=%b w_valid=%b w_addr=%0d expected 0100/1/0/0",
                     ifa.st, ifa.in_valid, ifa.w_valid, ifa.w_addr);
        end
        ifa.in_ready = 1;
        cyc = 0; dn = 0;
        while (ifa.st == S_CALC && cyc < 30000) begin
            if (ifa.in_valid && ifa.in_ready) begin
                t.addr = 32'(ifa.in_addr); t.ox = 32'(ifa.out_x); t.oy = 32'(ifa.out_y);
                t.first = ifa.win_first; t.last = ifa.win_last;
                got_q.push_back(t);
            end
            if (ifa.done) dn++;
            tick; cyc++;
        end
        checks++;
        if (cyc >= 30000) begin errors++; $display("FAIL a_calc_timeout: still in CALC after %0d cycles", cyc); end
        checks++;
        if (got_q.size() != 19600) begin
            errors++;
            $display("FAIL a_tap_count: %0d taps expected 19600", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL a_tap[%0d]: addr=%0d ox=%0d oy=%0d f=%b l=%b expected addr=%0d ox=%0d oy=%0d f=%b l=%b",
                         i, got_q[i].addr, got_q[i].ox, got_q[i].oy, got_q[i].first, got_q[i].last,
                         exp_q[i].addr, exp_q[i].ox, exp_q[i].oy, exp_q[i].first, exp_q[i].last);
            end
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got_q[i].addr !== 32'((i / 5) * 32 + (i % 5))) begin
                errors++;
                $display("FAIL a_first_window[%0d]: addr=%0d expected %0d", i, got_q[i].addr, (i / 5) * 32 + (i % 5));
            end
        end
        checks++;
        if (got_q[0].first !== 1'b1 || got_q[24].last !== 1'b1 || got_q[24].addr !== 32'd132) begin
            errors++;
            $display("FAIL a_window_flags: first=%b last=%b last_addr=%0d expected 1/1/132",
                     got_q[0].first, got_q[24].last, got_q[24].addr);
        end
        checks++;
        if (got_q[25].addr !== 32'd1 || got_q[25].ox !== 32'd1 || got_q[25].first !== 1'b1) begin
            errors++;
            $display("FAIL a_second_window: addr=%0d out_x=%0d first=%b expected 1/1/1",
                     got_q[25].addr, got_q[25].ox, got_q[25].first);
        end
        checks++;
        if (got_q[700].addr !== 32'd32 || got_q[700].oy !== 32'd1 || got_q[700].ox !== 32'd0) begin
            errors++;
            $display("FAIL a_row_wrap: addr=%0d out_y=%0d out_x=%0d expected 32/1/0",
                     got_q[700].addr, got_q[700].oy, got_q[700].ox);
        end
        checks++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1].addr !== 32'd1023) begin
            errors++;
            $display("FAIL a_last_addr: last tap addr expected 1023 (taps=%0d)", got_q.size());
        end
        checks++;
        if (ifa.st !== S_DONE || ifa.done !== 1'b1 || ifa.in_valid !== 1'b0) begin
            errors++;
            $display("FAIL a_done_state: st=%b done=%b in_valid=%b expected 1000/1/0", ifa.st, ifa.done, ifa.in_valid);
        end
        if (ifa.done) dn++;
        tick;
        checks++;
        if (ifa.st !== S_IDLE || ifa.done !== 1'b0) begin
            errors++;
            $display("FAIL a_back_to_idle: st=%b done=%b expected 0001/0", ifa.st, ifa.done);
        end
        for (int i = 0; i < 4; i++) begin if (ifa.done) dn++; tick; end
        checks++;
        if (dn != 1) begin errors++; $display("FAIL a_done_pulses: %0d pulses expected 1", dn); end
        ifa.in_ready = 0;
    endtask

    task automatic test_small_geometry;
        int n, cyc, wins;
        tap_t t;
        int exp_w0[8] = '{0, 1, 6, 7, 36, 37, 42, 43};
        build_model(6, 6, 2, 2, 2);
        got_q.delete();
        ifb.start = 1; tick; ifb.start = 0;
        n = 0;
        while (ifb.st == S_LOAD && n < 100) begin
            checks++;
            if (ifb.w_addr !== 4'(n) || ifb.w_valid !== 1'b1) begin
                errors++;
                $display("FAIL b_load_w_addr: w_addr=%0d w_valid=%b expected %0d/1", ifb.w_addr, ifb.w_valid, n);
            end
            n++; tick;
        end
        checks++;
        if (n != 9) begin errors++; $display("FAIL b_load_len: %0d cycles expected 9", n); end
        ifb.in_ready = 1;
        cyc = 0;
        while (ifb.st == S_CALC && cyc < 1000) begin
            if (ifb.in_valid && ifb.in_ready) begin
                t.addr = 32'(ifb.in_addr); t.ox = 32'(ifb.out_x); t.oy = 32'(ifb.out_y);
                t.first = ifb.win_first; t.last = ifb.win_last;
                got_q.push_back(t);
            end
            tick; cyc++;
        end
        checks++;
        if (got_q.size() != 72) begin errors++; $display("FAIL b_tap_count: %0d taps expected 72", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b_tap[%0d]: addr=%0d ox=%0d oy=%0d f=%b l=%b expected addr=%0d ox=%0d oy=%0d f=%b l=%b",
                         i, got_q[i].addr, got_q[i].ox, got_q[i].oy, got_q[i].first, got_q[i].last,
                         exp_q[i].addr, exp_q[i].ox, exp_q[i].oy, exp_q[i].first, exp_q[i].last);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q[i].addr !== 32'(exp_w0[i])) begin
                errors++;
                $display("FAIL b_window00[%0d]: addr=%0d expected %0d", i, got_q[i].addr, exp_w0[i]);
            end
        end
        checks++;
        if (got_q[8].addr !== 32'd2 || got_q[8].ox !== 32'd1) begin
            errors++;
            $display("FAIL b_window10: addr=%0d out_x=%0d expected 2/1", got_q[8].addr, got_q[8].ox);
        end
        wins = 0;
        foreach (got_q[i]) if (got_q[i].first) wins++;
        checks++;
        if (wins != 9) begin errors++; $display("FAIL b_window_count: %0d windows expected 9", wins); end
        checks++;
        if (ifb.st !== S_DONE || ifb.done !== 1'b1) begin
            errors++;
            $display("FAIL b_done: st=%b done=%b expected 1000/1", ifb.st, ifb.done);
        end
        tick;
        ifb.in_ready = 0;
    endtask

    task automatic test_backpressure;
        int cyc, stalls;
        tap_t t;
        logic [14:0] cur_v, prev_v;
        logic prev_stall;
        build_model(6, 6, 2, 2, 2);
        got_q.delete();
        ifb.start = 1; tick; ifb.start = 0;
        cyc = 0;
        while (ifb.st == S_LOAD && cyc < 100) begin tick; cyc++; end
        prev_stall = 0; prev_v = '0; stalls = 0; cyc = 0;
        while (ifb.st == S_CALC && cyc < 5000) begin
            cur_v = {ifb.in_addr, ifb.win_first, ifb.win_last, ifb.out_x, ifb.out_y, ifb.in_valid};
            if (prev_stall) begin
                checks++;
                if (cur_v !== prev_v) begin
                    errors++;
                    $display("FAIL bp_hold: outputs %h changed while stalled, expected %h", cur_v, prev_v);
                end
            end
            ifb.in_ready = 1'($urandom_range(0, 1));
            if (ifb.in_valid && ifb.in_ready) begin
                t.addr = 32'(ifb.in_addr); t.ox = 32'(ifb.out_x); t.oy = 32'(ifb.out_y);
                t.first = ifb.win_first; t.last = ifb.win_last;
                got_q.push_back(t);
            end
            prev_stall = ifb.in_valid && !ifb.in_ready;
            if (prev_stall) stalls++;
            prev_v = cur_v;
            tick; cyc++;
        end
        checks++;
        if (got_q.size() != exp_q.size() || stalls == 0) begin
            errors++;
            $display("FAIL bp_count: %0d taps (stalls %0d) expected %0d taps with stalls", got_q.size(), stalls, exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_tap[%0d]: addr=%0d expected %0d", i, got_q[i].addr, exp_q[i].addr);
            end
        end
        ifb.in_ready = 0;
        tick;
    endtask

    task automatic test_abort;
        int n, cyc, dn;
        ifa.start = 1; tick; ifa.start = 0;
        n = 1;
        while (ifa.st == S_LOAD && n < 40) begin tick; n++; end
        checks++;
        if (ifa.st !== S_LOAD || ifa.w_addr !== 8'd39) begin
            errors++;
            $display("FAIL abort_load_pos: st=%b w_addr=%0d expected 0010/39", ifa.st, ifa.w_addr);
        end
        ifa.abort = 1; tick; ifa.abort = 0;
        checks++;
        if (ifa.st !== S_IDLE || {ifa.w_addr, ifa.w_valid, ifa.in_valid, ifa.done} !== '0) begin
            errors++;
            $display("FAIL abort_load: st=%b w_addr=%0d w_valid=%b expected 0001/0/0", ifa.st, ifa.w_addr, ifa.w_valid);
        end
        ifa.start = 1; tick; ifa.start = 0;
        checks++;
        if (ifa.st !== S_LOAD || ifa.w_addr !== 8'd0 || ifa.w_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart1: st=%b w_addr=%0d expected 0010/0", ifa.st, ifa.w_addr);
        end
        cyc = 0;
        while (ifa.st != S_CALC && cyc < 400) begin tick; cyc++; end
        ifa.in_ready = 1;
        repeat (50) tick;
        checks++;
        if (ifa.st !== S_CALC || ifa.in_addr !== 10'd2 || ifa.out_x !== 5'd2 || ifa.win_first !== 1'b1) begin
            errors++;
            $display("FAIL abort_calc_pos: st=%b in_addr=%0d out_x=%0d expected 0100/2/2", ifa.st, ifa.in_addr, ifa.out_x);
        end
        ifa.abort = 1; tick; ifa.abort = 0;
        checks++;
        if (ifa.st !== S_IDLE || {ifa.in_addr, ifa.in_valid, ifa.win_first, ifa.win_last,
                                  ifa.out_x, ifa.out_y, ifa.done} !== '0) begin
            errors++;
            $display("FAIL abort_calc: st=%b in_addr=%0d in_valid=%b out_x=%0d expected 0001/0/0/0",
                     ifa.st, ifa.in_addr, ifa.in_valid, ifa.out_x);
        end
        dn = 0;
        repeat (5) begin if (ifa.done) dn++; tick; end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL abort_no_done: %0d pulses expected 0", dn); end
        ifa.in_ready = 0;
        ifa.start = 1; tick; ifa.start = 0;
        checks++;
        if (ifa.st !== S_LOAD || ifa.w_addr !== 8'd0 || ifa.w_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart2: st=%b w_addr=%0d expected 0010/0", ifa.st, ifa.w_addr);
        end
        ifa.abort = 1; tick; ifa.abort = 0;
    endtask

    task automatic test_start_ignored_and_reset;
        int cyc;
        ifb.start = 1; tick; ifb.start = 0;
        cyc = 0;
        while (ifb.st != S_CALC && cyc < 100) begin tick; cyc++; end
        ifb.in_ready = 1; ifb.start = 1;
        repeat (5) tick;
        ifb.start = 0;
        checks++;
        if (ifb.st !== S_CALC || ifb.in_addr !== 7'd37) begin
            errors++;
            $display("FAIL start_in_calc: st=%b in_addr=%0d expected 0100/37", ifb.st, ifb.in_addr);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (ifb.st !== S_IDLE || {ifb.w_addr, ifb.w_valid, ifb.in_addr, ifb.in_valid, ifb.win_first,
                                  ifb.win_last, ifb.out_x, ifb.out_y, ifb.done} !== '0) begin
            errors++;
            $display("FAIL async_reset: st=%b in_addr=%0d in_valid=%b expected 0001/0/0", ifb.st, ifb.in_addr, ifb.in_valid);
        end
        #2 rst_n = 1;
        tick;
        ifb.start = 1; tick; ifb.start = 0;
        checks++;
        if (ifb.st !== S_LOAD || ifb.w_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_restart: st=%b w_addr=%0d expected 0010/0", ifb.st, ifb.w_addr);
        end
        cyc = 0;
        while (ifb.st != S_DONE && cyc < 500) begin tick; cyc++; end
        checks++;
        if (ifb.st !== S_DONE || ifb.done !== 1'b1) begin
            errors++;
            $display("FAIL reach_done: st=%b done=%b expected 1000/1", ifb.st, ifb.done);
        end
        ifb.start = 1; tick; ifb.start = 0;
        checks++;
        if (ifb.st !== S_IDLE) begin errors++; $display("FAIL start_in_done: st=%b expected 0001", ifb.st); end
        tick;
        checks++;
        if (ifb.st !== S_IDLE || ifb.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_held: st=%b w_valid=%b expected 0001/0", ifb.st, ifb.w_valid);
        end
        ifb.in_ready = 0;
    endtask

    initial begin
        test_reset;
        test_default_run;
        test_small_geometry;
        test_backpressure;
        test_abort;
        test_start_ignored_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
